// File: rtl/rising_edge_detector_if.sv
// Level-in / pulse-out bundle for rising_edge_detector.
// The driver of the monitored levels is the master; the detector is the slave.
interface rising_edge_detector_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;

    modport master (output in, input out);
    modport slave  (input in, output out);
endinterface

// File: rtl/rising_edge_detector.sv
// Per-lane edge detector with optional input synchroniser chain.
// Every lane produces a registered single-cycle pulse on the selected edge.
module rising_edge_detector #(
    parameter int WIDTH       = 1,
    parameter int EDGE        = 0,
    parameter int SYNC_STAGES = 0
) (
    input logic                  clk,
    input logic                  rst,
    rising_edge_detector_if.slave bus
);

    // Unsupported edge codes fall back to rising-edge detection.
    localparam int EDGE_SEL = (EDGE >= 0 && EDGE <= 2) ? EDGE : 0;

    logic [WIDTH-1:0] sampled;
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] edge_hit;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign sampled = bus.in;
        end else begin : g_sync
            logic [WIDTH-1:0] stage_q [SYNC_STAGES];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        stage_q[s] <= '0;
                    end
                end else begin
                    stage_q[0] <= bus.in;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        stage_q[s] <= stage_q[s-1];
                    end
                end
            end

            assign sampled = stage_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        edge_hit = sampled & ~in_q;
        if (EDGE_SEL == 1) begin
            edge_hit = ~sampled & in_q;
        end else if (EDGE_SEL == 2) begin
            edge_hit = sampled ^ in_q;
        end
    end

    // The pulse is taken from a flop so the input never reaches out combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q  <= '0;
            out_q <= '0;
        end else begin
            in_q  <= sampled;
            out_q <= edge_hit;
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_rising_edge_detector.sv
// Self-checking bench: five detector configurations driven side by side and
// compared against a sample-history reference model.
module tb_rising_edge_detector;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rising_edge_detector_if #(.WIDTH(1)) if_rise ();
    rising_edge_detector_if #(.WIDTH(1)) if_fall ();
    rising_edge_detector_if #(.WIDTH(1)) if_both ();
    rising_edge_detector_if #(.WIDTH(4)) if_sync ();
    rising_edge_detector_if #(.WIDTH(1)) if_bad  ();

    rising_edge_detector #(.WIDTH(1), .EDGE(0), .SYNC_STAGES(0)) dut_rise (.clk(clk), .rst(rst), .bus(if_rise));
    rising_edge_detector #(.WIDTH(1), .EDGE(1), .SYNC_STAGES(0)) dut_fall (.clk(clk), .rst(rst), .bus(if_fall));
    rising_edge_detector #(.WIDTH(1), .EDGE(2), .SYNC_STAGES(0)) dut_both (.clk(clk), .rst(rst), .bus(if_both));
    rising_edge_detector #(.WIDTH(4), .EDGE(0), .SYNC_STAGES(2)) dut_sync (.clk(clk), .rst(rst), .bus(if_sync));
    rising_edge_detector #(.WIDTH(1), .EDGE(3), .SYNC_STAGES(0)) dut_bad  (.clk(clk), .rst(rst), .bus(if_bad));

    localparam int NDUT = 5;
    localparam int cfg_edge   [NDUT] = '{0, 1, 2, 0, 3};
    localparam int cfg_stages [NDUT] = '{0, 0, 0, 2, 0};
    localparam int cfg_width  [NDUT] = '{1, 1, 1, 4, 1};
    string names [NDUT] = '{"rise", "fall", "both", "sync", "bad"};

    int checks = 0;
    int errors = 0;

    logic [3:0] drv  [NDUT];
    // hist[d][k] = input value clocked in k posedges ago (k=0 is the latest).
    logic [3:0] hist [NDUT][8];

    function automatic logic [3:0] laneMask(input int d);
        return (cfg_width[d] == 4) ? 4'hF : 4'h1;
    endfunction

    // An edge is judged on the sample the detector sees after its synchroniser
    // delay versus the sample one clock before that.
    function automatic logic [3:0] modelOut(input int d);
        logic [3:0] cur;
        logic [3:0] prv;
        logic [3:0] r;
        cur = hist[d][cfg_stages[d]];
        prv = hist[d][cfg_stages[d] + 1];
        case (cfg_edge[d])
            1:       r = ~cur & prv;
            2:       r = cur ^ prv;
            default: r = cur & ~prv;
        endcase
        return r & laneMask(d);
    endfunction

    function automatic logic [3:0] observed(input int d);
        case (d)
            0:       return {3'b000, if_rise.out};
            1:       return {3'b000, if_fall.out};
            2:       return {3'b000, if_both.out};
            3:       return if_sync.out;
            default: return {3'b000, if_bad.out};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [3:0] observed_val, input logic [3:0] expected_val);
        checks++;
        if (observed_val !== expected_val) begin
            errors++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed_val, expected_val);
        end
    endtask

    task automatic checkAll(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("%s_%s", tag, names[d]), observed(d), modelOut(d));
        end
    endtask

    task automatic clearHistory();
        for (int d = 0; d < NDUT; d++) begin
            for (int k = 0; k < 8; k++) begin
                hist[d][k] = 4'h0;
            end
        end
    endtask

    task automatic pushSamples();
        for (int d = 0; d < NDUT; d++) begin
            for (int k = 7; k > 0; k--) begin
                hist[d][k] = hist[d][k-1];
            end
            hist[d][0] = rst ? 4'h0 : (drv[d] & laneMask(d));
        end
    endtask

    task automatic applyStimulus();
        if_rise.in = drv[0][0];
        if_fall.in = drv[1][0];
        if_both.in = drv[2][0];
        if_sync.in = drv[3];
        if_bad.in  = drv[4][0];
    endtask

    // One clock: outputs must hold across the falling edge, then update after the rising edge.
    task automatic stepCycle();
        @(negedge clk);
        #1;
        checkAll("neg");
        @(posedge clk);
        pushSamples();
        #1;
        checkAll("pos");
    endtask

    initial begin
        clearHistory();
        drv = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
        applyStimulus();

        #22;
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("reset_%s", names[d]), observed(d), 4'h0);
        end
        rst = 1'b0;

        stepCycle();
        checkOutput("fall_release_high", observed(1), 4'h0);
        stepCycle();

        drv = '{4'h1, 4'h0, 4'h1, 4'h5, 4'h1};
        applyStimulus();
        #1;
        checkOutput("rise_before_edge", observed(0), 4'h0);
        stepCycle();
        checkOutput("rise_pulse", observed(0), 4'h1);
        checkOutput("fall_pulse", observed(1), 4'h1);
        checkOutput("both_first", observed(2), 4'h1);
        checkOutput("bad_as_rise", observed(4), 4'h1);
        checkOutput("sync_not_yet", observed(3), 4'h0);

        drv = '{4'h1, 4'h1, 4'h0, 4'h5, 4'h1};
        applyStimulus();
        stepCycle();
        checkOutput("rise_held", observed(0), 4'h0);
        checkOutput("fall_on_rise", observed(1), 4'h0);
        checkOutput("both_second", observed(2), 4'h1);
        checkOutput("sync_still_not", observed(3), 4'h0);
        stepCycle();
        checkOutput("rise_held2", observed(0), 4'h0);
        checkOutput("both_done", observed(2), 4'h0);
        checkOutput("sync_pulse", observed(3), 4'h5);
        stepCycle();
        checkOutput("sync_one_cycle", observed(3), 4'h0);

        drv[0] = 4'h0;
        applyStimulus();
        stepCycle();
        drv[0] = 4'h1;
        applyStimulus();
        stepCycle();
        checkOutput("rise_again", observed(0), 4'h1);
        #2;
        rst = 1'b1;
        clearHistory();
        #1;
        checkOutput("async_reset_mid_pulse", observed(0), 4'h0);
        stepCycle();
        rst = 1'b0;
        stepCycle();
        checkOutput("rise_after_release", observed(0), 4'h1);
        checkOutput("fall_after_release", observed(1), 4'h0);
        stepCycle();
        checkOutput("rise_after_release_end", observed(0), 4'h0);

        drv[0] = 4'h0;
        applyStimulus();
        stepCycle();
        drv[0] = 4'h1;
        applyStimulus();
        #2;
        drv[0] = 4'h0;
        applyStimulus();
        stepCycle();
        checkOutput("glitch_ignored", observed(0), 4'h0);

        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int d = 0; d < NDUT; d++) begin
                drv[d] = 4'($urandom_range(0, 15)) & laneMask(d);
            end
            applyStimulus();
            if ($urandom_range(0, 49) == 0) begin
                #3;
                rst = 1'b1;
                clearHistory();
                #1;
                checkAll("async_rst");
                stepCycle();
                rst = 1'b0;
            end
            stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
